// File: rtl/latch_bank_arbiter_if.sv
// Latch write-port handshake bundle for latch_bank_arbiter.
// The master side is the requester logic; the slave side is the arbiter.
interface latch_bank_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [DATA_W-1:0]       latch_d;
  logic                    latch_en;
  logic                    done;
  logic                    busy;

  modport master (
    output req, wdata,
    input  gnt, latch_d, latch_en, done, busy
  );

  modport slave (
    input  req, wdata,
    output gnt, latch_d, latch_en, done, busy
  );
endinterface

// File: rtl/latch_bank_arbiter.sv
// Round-robin arbiter sequencing one shared latch port: SETUP, OPEN, HOLD.
// Define LATCH_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module latch_bank_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int OPEN_CYCLES = 2
) (
  input logic                 clk,
  input logic                 reset,
  latch_bank_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(OPEN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE, SETUP, OPEN, HOLD
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [DATA_W-1:0] data_q;
  logic              en_q;
  logic              done_q;
  logic              busy_q;
  logic [PW-1:0]     win_d;

`ifndef LATCH_ARB_FIXED_PRIO_EN
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win_q;
  logic [PW-1:0] idx;

  // Scan downward so the slot nearest ptr+1 is assigned last and wins.
  always_comb begin
    win_d = '0;
    idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = PW'((int'(ptr_q) + k) % N_REQ);
      if (bus.req[idx]) win_d = idx;
    end
  end
`else
  always_comb begin
    win_d = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req[k]) win_d = PW'(k);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifndef LATCH_ARB_FIXED_PRIO_EN
      ptr_q   <= PW'(N_REQ - 1);
      win_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          en_q   <= 1'b0;
          done_q <= 1'b0;
          if (|bus.req) begin
            gnt_q   <= N_REQ'(1) << win_d;
            data_q  <= bus.wdata[win_d*DATA_W +: DATA_W];
            busy_q  <= 1'b1;
            state_q <= SETUP;
`ifndef LATCH_ARB_FIXED_PRIO_EN
            win_q   <= win_d;
`endif
          end else begin
            gnt_q  <= '0;
            busy_q <= 1'b0;
          end
        end
        SETUP: begin
          en_q    <= 1'b1;
          cnt_q   <= CW'(1);
          state_q <= OPEN;
        end
        OPEN: begin
          if (cnt_q == CW'(OPEN_CYCLES)) begin
            en_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HOLD: begin
          done_q  <= 1'b0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifndef LATCH_ARB_FIXED_PRIO_EN
          ptr_q   <= win_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.latch_d  = data_q;
  assign bus.latch_en = en_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Randomised self-checking bench for latch_bank_arbiter.
// Expected winners come from a pointer-based arbitration model.
module tb_latch_bank_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int OC = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  latch_bank_arbiter_if #(.N_REQ(N), .DATA_W(W)) ifc ();

  latch_bank_arbiter #(
    .N_REQ(N), .DATA_W(W), .OPEN_CYCLES(OC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ptr;

  function automatic int exp_winner(input logic [N-1:0] r, input int p);
`ifdef LATCH_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
`endif
    return -1;
  endfunction

  logic [W-1:0] prev_d;
  logic         prev_done;

  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if (ifc.latch_en && ifc.latch_d !== prev_d) begin
        n_bad++;
        $display("FAIL en_data_stable: latch_d %h was %h", ifc.latch_d, prev_d);
      end
      n_cmp++;
      if (!$onehot0(ifc.gnt)) begin
        n_bad++;
        $display("FAIL gnt_onehot: gnt %b required one-hot or zero", ifc.gnt);
      end
      n_cmp++;
      if (ifc.done && prev_done) begin
        n_bad++;
        $display("FAIL done_twice: done high %0d cycles running required 1", 2);
      end
      n_cmp++;
      if (ifc.latch_en && (ifc.done || !ifc.busy || ifc.gnt == '0)) begin
        n_bad++;
        $display("FAIL en_state: en=1 done=%b busy=%b gnt=%b", ifc.done, ifc.busy, ifc.gnt);
      end
    end
    prev_d    <= ifc.latch_d;
    prev_done <= ifc.done;
  end

  // Watches one transaction; mode 1 drops req and scrambles wdata once
  // latch_en opens, mode 2 swaps req to requester 2 at that point.
  task automatic observe_txn(
    input  int           mode,
    output logic [N-1:0] g,
    output logic [W-1:0] d,
    output logic [W-1:0] d_end,
    output int           g_rel,
    output int           en_first,
    output int           en_cnt,
    output int           done_rel,
    output int           done_cnt,
    output int           idle_rel,
    output bit           g_stable,
    output bit           timeout
  );
    g = '0; d = '0; d_end = '0;
    g_rel = -1; en_first = -1; en_cnt = 0;
    done_rel = -1; done_cnt = 0; idle_rel = -1;
    g_stable = 1'b1; timeout = 1'b1;
    for (int rel = 1; rel <= 20; rel++) begin
      @(posedge clk); #1;
      if (g_rel < 0 && ifc.gnt != '0) begin
        g_rel = rel; g = ifc.gnt; d = ifc.latch_d;
      end else if (g_rel >= 0 && ifc.busy && ifc.gnt !== g) begin
        g_stable = 1'b0;
      end
      if (ifc.latch_en) begin
        en_cnt++;
        if (en_first < 0) en_first = rel;
        if (en_cnt == 1 && mode == 1) begin
          ifc.req   = '0;
          ifc.wdata = ~ifc.wdata;
        end
        if (en_cnt == 1 && mode == 2) ifc.req = 4'b0100;
      end
      if (ifc.done) begin
        done_cnt++; done_rel = rel;
      end
      if (g_rel >= 0 && !ifc.busy) begin
        idle_rel = rel; d_end = ifc.latch_d; timeout = 1'b0;
        break;
      end
    end
  endtask

  logic [N-1:0] g;
  logic [W-1:0] d, d_end;
  int g_rel, en_first, en_cnt, done_rel, done_cnt, idle_rel;
  bit g_stable, to;

  task automatic test_reset();
    reset = 1'b1;
    ifc.req = '0;
    ifc.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ifc.gnt, ifc.latch_d, ifc.latch_en, ifc.done, ifc.busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: gnt=%b d=%h en=%b done=%b busy=%b required 0",
               ifc.gnt, ifc.latch_d, ifc.latch_en, ifc.done, ifc.busy);
    end
    #2 reset = 1'b0;
    ptr = N - 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    ifc.wdata = {$urandom} & ~32'hFF | 32'hA5;
    ifc.req = 4'b0001;
    observe_txn(0, g, d, d_end, g_rel, en_first, en_cnt, done_rel, done_cnt, idle_rel, g_stable, to);
    ifc.req = '0;
    n_cmp++;
    if (to || g !== 4'b0001 || g_rel != 1) begin
      n_bad++; $display("FAIL single_gnt: gnt=%b at %0d required 0001 at 1", g, g_rel);
    end
    n_cmp++;
    if (d !== 8'hA5) begin
      n_bad++; $display("FAIL single_data: latch_d=%h required a5", d);
    end
    n_cmp++;
    if (en_first != 2 || en_cnt != OC) begin
      n_bad++; $display("FAIL single_en: first=%0d len=%0d required 2/%0d", en_first, en_cnt, OC);
    end
    n_cmp++;
    if (done_rel != OC + 2 || done_cnt != 1) begin
      n_bad++; $display("FAIL single_done: at %0d x%0d required %0d x1", done_rel, done_cnt, OC + 2);
    end
    n_cmp++;
    if (idle_rel != OC + 3) begin
      n_bad++; $display("FAIL single_idle: busy low at %0d required %0d", idle_rel, OC + 3);
    end
    ptr = exp_winner(4'b0001, ptr);
  endtask

  task automatic test_rotation();
    int w;
    test_reset();
    ifc.req = '1;
    for (int t = 0; t < 2 * N; t++) begin
      for (int i = 0; i < N; i++)
        ifc.wdata[i*W +: W] = W'((i << 4) | $urandom_range(0, 15));
      w = exp_winner(ifc.req, ptr);
      observe_txn(0, g, d, d_end, g_rel, en_first, en_cnt, done_rel, done_cnt, idle_rel, g_stable, to);
      n_cmp++;
      if (to || g !== N'(1 << w)) begin
        n_bad++; $display("FAIL rot_gnt[%0d]: gnt=%b required %b", t, g, N'(1 << w));
      end
      n_cmp++;
      if (d !== ifc.wdata[w*W +: W]) begin
        n_bad++; $display("FAIL rot_data[%0d]: latch_d=%h required %h", t, d, ifc.wdata[w*W +: W]);
      end
      n_cmp++;
      if (idle_rel != OC + 3) begin
        n_bad++; $display("FAIL rot_len[%0d]: idle at %0d required %0d", t, idle_rel, OC + 3);
      end
      ptr = w;
    end
    ifc.req = '0;
  endtask

  task automatic test_drop_midway();
    int w;
    logic [W-1:0] exp_d;
    ifc.req = N'($urandom_range(1, (1 << N) - 1));
    ifc.wdata = $urandom;
    w = exp_winner(ifc.req, ptr);
    exp_d = ifc.wdata[w*W +: W];
    observe_txn(1, g, d, d_end, g_rel, en_first, en_cnt, done_rel, done_cnt, idle_rel, g_stable, to);
    ifc.req = '0;
    n_cmp++;
    if (to || g !== N'(1 << w) || !g_stable) begin
      n_bad++; $display("FAIL drop_gnt: gnt=%b stable=%b required %b", g, g_stable, N'(1 << w));
    end
    n_cmp++;
    if (d !== exp_d || d_end !== exp_d) begin
      n_bad++; $display("FAIL drop_data: latch_d=%h/%h required %h", d, d_end, exp_d);
    end
    n_cmp++;
    if (en_cnt != OC || done_cnt != 1) begin
      n_bad++; $display("FAIL drop_window: en=%0d done=%0d required %0d/1", en_cnt, done_cnt, OC);
    end
    ptr = w;
  endtask

  task automatic test_async_reset();
    bit seen;
    seen = 1'b0;
    ifc.req = 4'b0010;
    ifc.wdata = $urandom;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      seen = ifc.latch_en;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL arst_open: latch_en=%b required 1 within 10 cycles", seen);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({ifc.latch_en, ifc.gnt, ifc.busy, ifc.done} !== '0) begin
      n_bad++; $display("FAIL arst_clear: en=%b gnt=%b busy=%b done=%b required 0",
                        ifc.latch_en, ifc.gnt, ifc.busy, ifc.done);
    end
    ifc.req = 4'b1000;
    #3 reset = 1'b0;
    ptr = N - 1;
    observe_txn(0, g, d, d_end, g_rel, en_first, en_cnt, done_rel, done_cnt, idle_rel, g_stable, to);
    ifc.req = '0;
    n_cmp++;
    if (to || g !== 4'b1000 || g_rel != 1 || !g_stable) begin
      n_bad++; $display("FAIL arst_regrant: gnt=%b at %0d required 1000 at 1", g, g_rel);
    end
    ptr = exp_winner(4'b1000, ptr);
  endtask

  task automatic test_held_off();
    ifc.req = 4'b0010;
    ifc.wdata = $urandom;
    observe_txn(2, g, d, d_end, g_rel, en_first, en_cnt, done_rel, done_cnt, idle_rel, g_stable, to);
    n_cmp++;
    if (to || g !== 4'b0010 || !g_stable || done_cnt != 1) begin
      n_bad++; $display("FAIL held_first: gnt=%b stable=%b done=%0d required 0010/1/1", g, g_stable, done_cnt);
    end
    n_cmp++;
    if (ifc.gnt !== '0 || ifc.busy !== 1'b0) begin
      n_bad++; $display("FAIL held_idle: gnt=%b busy=%b required 0/0", ifc.gnt, ifc.busy);
    end
    ptr = exp_winner(4'b0010, ptr);
    observe_txn(0, g, d, d_end, g_rel, en_first, en_cnt, done_rel, done_cnt, idle_rel, g_stable, to);
    ifc.req = '0;
    n_cmp++;
    if (to || g !== 4'b0100 || g_rel != 1) begin
      n_bad++; $display("FAIL held_second: gnt=%b at %0d required 0100 at 1", g, g_rel);
    end
    ptr = exp_winner(4'b0100, ptr);
  endtask

  task automatic test_random();
    int w;
    for (int t = 0; t < 30; t++) begin
      ifc.req = N'($urandom_range(0, (1 << N) - 1));
      ifc.wdata = $urandom;
      if (ifc.req == '0) begin
        @(posedge clk); #1;
        n_cmp++;
        if (ifc.gnt !== '0 || ifc.busy !== 1'b0) begin
          n_bad++; $display("FAIL rnd_idle[%0d]: gnt=%b busy=%b required 0/0", t, ifc.gnt, ifc.busy);
        end
      end else begin
        w = exp_winner(ifc.req, ptr);
        observe_txn(0, g, d, d_end, g_rel, en_first, en_cnt, done_rel, done_cnt, idle_rel, g_stable, to);
        n_cmp++;
        if (to || g !== N'(1 << w) || d !== ifc.wdata[w*W +: W]) begin
          n_bad++; $display("FAIL rnd_txn[%0d]: gnt=%b d=%h required %b/%h",
                            t, g, d, N'(1 << w), ifc.wdata[w*W +: W]);
        end
        n_cmp++;
        if (en_cnt != OC || done_rel != OC + 2 || idle_rel != OC + 3) begin
          n_bad++; $display("FAIL rnd_timing[%0d]: en=%0d done@%0d idle@%0d required %0d/%0d/%0d",
                            t, en_cnt, done_rel, idle_rel, OC, OC + 2, OC + 3);
        end
        ptr = w;
      end
    end
    ifc.req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_drop_midway();
    test_async_reset();
    test_held_off();
    test_random();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
